// File: rtl/perf_counter_bank.sv
// Performance counter bank: one cycle counter plus NUM_EVT event counters with halt freeze,
// sticky overflow, wrap/saturate mode and registered readout. Optional snapshot shadows: PERF_SNAPSHOT_EN.
module perf_counter_bank #(
  parameter int NUM_EVT  = 8,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int AW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               halt,
  input  logic               clr,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [AW-1:0]      rd_addr,
`ifdef PERF_SNAPSHOT_EN
  input  logic               snap,
  output logic               snap_valid,
`endif
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               halted
);

  typedef enum logic {RUN, FROZEN} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state;
  logic             count_now;
  logic [NUM_EVT:0] inc;
  logic [NUM_EVT:0] ovf_nxt;
  logic [CNT_W-1:0] cnt     [NUM_EVT+1];
  logic [CNT_W-1:0] cnt_nxt [NUM_EVT+1];
  logic [CNT_W-1:0] src     [NUM_EVT+1];
  logic [CNT_W-1:0] rd_sel;

  // The halt-entry cycle (RUN) and the halt-exit cycle (FROZEN, halt low) both count.
  assign count_now = en && ((state == RUN) || !halt);

  always_comb begin
    inc[0] = count_now;
    for (int k = 1; k <= NUM_EVT; k++) begin
      inc[k] = count_now & evt[k-1];
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    for (int k = 0; k <= NUM_EVT; k++) begin
      cnt_nxt[k] = cnt[k];
      if (inc[k]) begin
        if (cnt[k] == ALL_ONES) begin
          ovf_nxt[k] = 1'b1;
          cnt_nxt[k] = (SATURATE != 0) ? ALL_ONES : '0;
        end else begin
          cnt_nxt[k] = cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (en) begin
      case (state)
        RUN: begin
          if (halt) begin
            state  <= FROZEN;
            halted <= 1'b1;
          end
        end
        FROZEN: begin
          if (!halt) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Clear discards any event arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k <= NUM_EVT; k++) begin
        cnt[k] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int k = 0; k <= NUM_EVT; k++) begin
        cnt[k] <= cnt_nxt[k];
      end
      ovf <= ovf_nxt;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NUM_EVT+1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k <= NUM_EVT; k++) begin
        shadow[k] <= '0;
      end
      snap_valid <= 1'b0;
    end else if (snap) begin
      for (int k = 0; k <= NUM_EVT; k++) begin
        shadow[k] <= cnt[k];
      end
      snap_valid <= 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k <= NUM_EVT; k++) begin
      src[k] = shadow[k];
    end
  end
`else
  always_comb begin
    for (int k = 0; k <= NUM_EVT; k++) begin
      src[k] = cnt[k];
    end
  end
`endif

  // Addresses beyond the last event counter fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_addr == AW'(k)) begin
        rd_sel = src[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: wrap and saturate instances (CNT_W=8) checked each cycle
// against an arithmetic reference model; snapshot checks when PERF_SNAPSHOT_EN is defined.
module tb_perf_counter_bank;

  localparam int NE   = 8;
  localparam int W    = 8;
  localparam int MAXV = 255;

  logic          clk;
  logic          rst, en, halt, clr, tb_snap;
  logic [NE-1:0] evt;
  logic [3:0]    rd_addr;
  logic [W-1:0]  rd_data_w, rd_data_s;
  logic [NE:0]   ovf_w, ovf_s;
  logic          halted_w, halted_s;
`ifdef PERF_SNAPSHOT_EN
  logic          snap_valid_w, snap_valid_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_w    [0:NE];
  int m_s    [0:NE];
  int m_sh_w [0:NE];
  int m_sh_s [0:NE];
  bit [NE:0] m_ovf;
  bit        m_frozen;
  bit        m_sv;
  int        m_rd_w, m_rd_s;

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(W), .SATURATE(0), .AW(4)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .clr(clr), .evt(evt), .rd_addr(rd_addr),
`ifdef PERF_SNAPSHOT_EN
    .snap(tb_snap), .snap_valid(snap_valid_w),
`endif
    .rd_data(rd_data_w), .ovf(ovf_w), .halted(halted_w)
  );

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(W), .SATURATE(1), .AW(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .clr(clr), .evt(evt), .rd_addr(rd_addr),
`ifdef PERF_SNAPSHOT_EN
    .snap(tb_snap), .snap_valid(snap_valid_s),
`endif
    .rd_data(rd_data_s), .ovf(ovf_s), .halted(halted_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: counters as plain integers, wrap via modulo, saturate via min.
  task automatic modelStep();
    int  src_w [0:NE];
    int  src_s [0:NE];
    bit  cnt_on;
`ifdef PERF_SNAPSHOT_EN
    src_w = m_sh_w;
    src_s = m_sh_s;
`else
    src_w = m_w;
    src_s = m_s;
`endif
    if (rst) begin
      for (int k = 0; k <= NE; k++) begin
        m_w[k] = 0; m_s[k] = 0; m_sh_w[k] = 0; m_sh_s[k] = 0;
      end
      m_ovf = '0; m_frozen = 1'b0; m_sv = 1'b0; m_rd_w = 0; m_rd_s = 0;
    end else begin
      if (rd_addr <= NE) begin
        m_rd_w = src_w[rd_addr];
        m_rd_s = src_s[rd_addr];
      end else begin
        m_rd_w = 0;
        m_rd_s = 0;
      end
      if (clr) begin
        for (int k = 0; k <= NE; k++) begin
          m_sh_w[k] = 0; m_sh_s[k] = 0;
        end
        m_sv = 1'b0;
      end else if (tb_snap) begin
        m_sh_w = m_w;
        m_sh_s = m_s;
        m_sv   = 1'b1;
      end
      cnt_on = en && (!m_frozen || !halt);
      if (en) m_frozen = halt;
      if (clr) begin
        for (int k = 0; k <= NE; k++) begin
          m_w[k] = 0; m_s[k] = 0;
        end
        m_ovf = '0;
      end else if (cnt_on) begin
        for (int k = 0; k <= NE; k++) begin
          if (k == 0 || evt[k-1]) begin
            if (m_w[k] == MAXV) m_ovf[k] = 1'b1;
            m_w[k] = (m_w[k] + 1) % (MAXV + 1);
            if (m_s[k] < MAXV) m_s[k] = m_s[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("rd_data_wrap", rd_data_w, m_rd_w);
    check("rd_data_sat",  rd_data_s, m_rd_s);
    check("ovf_wrap",     ovf_w,     m_ovf);
    check("ovf_sat",      ovf_s,     m_ovf);
    check("halted_wrap",  halted_w,  m_frozen);
    check("halted_sat",   halted_s,  m_frozen);
`ifdef PERF_SNAPSHOT_EN
    check("snap_valid_wrap", snap_valid_w, m_sv);
    check("snap_valid_sat",  snap_valid_s, m_sv);
`endif
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit h, input bit c,
                               input logic [NE-1:0] ev, input logic [3:0] a, input bit s);
    rst = r; en = e; halt = h; clr = c; evt = ev; rd_addr = a; tb_snap = s;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; halt = 1'b0; clr = 1'b0; evt = '0; rd_addr = '0; tb_snap = 1'b0;
    #2;
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
    check("reset_rd_data", rd_data_w, 0);
    check("reset_ovf", ovf_w, 0);
    check("reset_halted", halted_w, 0);

    // Ten run cycles with evt[0] pulsed three times.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, (i == 2 || i == 5 || i == 8) ? 8'h01 : 8'h00, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
`ifndef PERF_SNAPSHOT_EN
    check("basic_cycle_count", rd_data_w, 10);
`endif
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);
`ifndef PERF_SNAPSHOT_EN
    check("basic_evt0_count", rd_data_w, 3);
`endif

    // Halt: four run cycles, then halt held five cycles, evt[1] on even cycles.
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, (i >= 4), 0, (i % 2 == 0) ? 8'h02 : 8'h00, 0, 0);
    end
    applyStimulus(0, 1, 1, 0, 8'h02, 0, 0);
    check("halt_halted_const", halted_w, 1);
`ifndef PERF_SNAPSHOT_EN
    check("halt_cycle_frozen", rd_data_w, 5);
`endif
    applyStimulus(0, 1, 1, 0, 8'h02, 2, 0);
`ifndef PERF_SNAPSHOT_EN
    check("halt_evt1_frozen", rd_data_w, 3);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h02, 0, 0);
    check("halt_released", halted_w, 0);

    // 257 strobes on evt[2]: wrap lands on 1, saturate sticks at 255.
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 257; i++) applyStimulus(0, 1, 0, 0, 8'h04, 3, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 3, 0);
`ifndef PERF_SNAPSHOT_EN
    check("ovf_wrap_value", rd_data_w, 1);
    check("ovf_sat_value", rd_data_s, 255);
`endif
    check("ovf_wrap_flags", ovf_w, 9'h009);
    check("ovf_sat_flags", ovf_s, 9'h009);

    // Clear in the same cycle as all-ones events, then en low holds everything.
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, NE'($urandom), 4'(i % 9), 0);
    applyStimulus(0, 1, 0, 1, 8'hFF, 0, 0);
    check("clr_ovf", ovf_w, 0);
    check("clr_halted", halted_w, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, NE'($urandom), 4'(i), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
`ifndef PERF_SNAPSHOT_EN
    check("clr_hold_cycle", rd_data_w, 0);
`endif

    // Out-of-range readout, then reset while frozen.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'hA5, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 4'(NE + 1), 0);
    check("oob_addr9", rd_data_w, 0);
    applyStimulus(0, 1, 1, 0, 8'h00, 4'd15, 0);
    check("oob_addr15", rd_data_s, 0);
    applyStimulus(0, 1, 1, 0, 8'hFF, 0, 0);
    check("frozen_before_rst", halted_s, 1);
    applyStimulus(1, 1, 1, 0, 8'hFF, 0, 0);
    check("rst_frozen_rd", rd_data_w, 0);
    check("rst_frozen_ovf", ovf_s, 0);
    check("rst_frozen_halted", halted_w, 0);

`ifdef PERF_SNAPSHOT_EN
    // Snapshot after seven counted cycles, then snap together with clr.
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 8'h01, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h01, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 8'h01, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 0);
    check("snap_cycle_value", rd_data_w, 7);
    check("snap_valid_set", snap_valid_w, 1);
    applyStimulus(0, 1, 0, 1, 8'h00, 0, 1);
    check("snap_clr_valid", snap_valid_w, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 0);
    check("snap_clr_value", rd_data_w, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 39) == 0,
                    NE'($urandom),
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of pipeline performance counters for the streamline CPU: one cycle counter plus NUM_EVT event counters.
- Each event counter is driven by a single-cycle event strobe from the pipeline (j/jal/jr, branch types, correct predictions, stalls, ...).
- Adds global enable, halt-aware freeze, synchronous clear, sticky overflow flags, selectable wrap/saturate mode and an addressed registered readout.
- Sits beside the pipeline and feeds the debug/display path.

Parameters:
- NUM_EVT, 8, number of event counters (1..15).
- CNT_W, 32, width of every counter (8..64).
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at all-ones.
- AW, 4, readout address width; must satisfy 2^AW >= NUM_EVT+1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  global count enable; when low, nothing counts and state holds.
- halt  in  1  CPU halt indication, level.
- clr  in  1  synchronous clear of all counters and overflow flags.
- evt  in  NUM_EVT  event strobes; bit i adds 1 to event counter i in that cycle.
- rd_addr  in  AW  0 = cycle counter; k = event counter k-1 (1..NUM_EVT).
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = event k-1.
- halted  out  1  high while in FROZEN state.

Behaviour:
- Reset: all counters 0, ovf 0, rd_data 0, state RUN, halted 0.
- States:
  - RUN, FROZEN.
  - RUN→FROZEN on any cycle with en=1 and halt=1. That cycle is the halt-entry cycle and still counts normally (cycle +1, events counted).
  - FROZEN→RUN on the first cycle with halt=0. That cycle counts normally.
  - In FROZEN, the cycle counter and event counters do not change regardless of evt.
  - en=0: no state transition, no counting; counters, ovf and state hold.
- Counting in RUN (en=1):
  - Cycle counter +1 every cycle, including the halt-entry cycle.
  - Event counter i +1 when evt[i]=1. All channels are independent, and multiple strobes in one cycle all count.
- Width rules:
  - An increment from all-ones sets the matching ovf bit.
  - SATURATE=0: result is 0.
  - SATURATE=1: value stays all-ones. ovf is still set, and further strobes leave value and flag unchanged.
- clr:
  - Zeroes all counters and ovf next edge. State, halted and rd_data are unaffected.
  - An event in the same cycle as clr is discarded.
  - Priority: rst > clr > count.
- Readout:
  - rd_data <= selected counter value as of the start of the cycle, one-cycle latency.
  - Reading does not modify the counter.
  - rd_addr > NUM_EVT returns 0.
- halted = registered state==FROZEN.
- ovf is cleared only by rst or clr.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Adds input snap (1 bit) and output snap_valid (1 bit), plus one shadow register per counter.
  - On snap=1, every shadow takes its live counter value as of that edge, coherently, and snap_valid <= 1.
  - rd_data reads shadows instead of live counters.
  - clr also clears shadows and snap_valid. rst clears all of them.
  - snap and clr in the same cycle: clr wins.
- Undefined: snap/snap_valid ports are absent and rd_data reads live counters.

Test Plan:
- Reset, then en=1, halt=0 for 10 cycles with evt[0] pulsed 3 times → rd_addr=0 gives 10 and rd_addr=1 gives 3, each one cycle after the address is applied.
- halt=1 held 5 cycles starting after cycle 4 of run, evt[1] toggling throughout → cycle counter = 5 (4 + entry cycle), evt[1] counts only up to and including the entry cycle, halted=1 from the cycle after entry; drop halt → counting resumes.
- CNT_W=8, SATURATE=0, 257 evt[2] strobes → counter = 1, ovf[3]=1; SATURATE=1 → counter = 255, ovf[3]=1.
- clr asserted in the same cycle as evt=all-ones after 20 run cycles → all counters 0 and ovf 0 next cycle, state unchanged; en=0 for 6 cycles → values hold.
- rd_addr = NUM_EVT+1 → rd_data 0; rst asserted mid-run while FROZEN → everything 0, state RUN.
- PERF_SNAPSHOT_EN: snap at cycle 7, run 10 more cycles → rd_addr=0 returns 7 and snap_valid=1; snap with clr in the same cycle → shadows 0, snap_valid 0.
